// File: rtl/axis_extremum_tracker.sv
// Per-lane running min/max over windows of 2^log_count accepted AXI-Stream beats, with
// thresholds shrunk toward the window centre one cycle after each window closes.
module axis_extremum_tracker #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int CHANNELS     = 2,
    parameter int COUNT_WIDTH  = 32
) (
    input  logic                             aclk,
    input  logic                             areset,
    input  logic [4:0]                       log_count,
    input  logic [2:0]                       shift,
    input  logic                             clear,
    output logic [CHANNELS*SAMPLE_WIDTH-1:0] lower_threshold,
    output logic [CHANNELS*SAMPLE_WIDTH-1:0] upper_threshold,
    output logic                             thresholds_valid,
    output logic                             update,
    input  logic                             S_AXIS_tvalid,
    input  logic [CHANNELS*SAMPLE_WIDTH-1:0] S_AXIS_tdata,
    output logic                             S_AXIS_tready
);
    localparam int SW = SAMPLE_WIDTH;
    localparam logic signed [SW-1:0] POS_MAX = {1'b0, {(SW-1){1'b1}}};
    localparam logic signed [SW-1:0] NEG_MIN = {1'b1, {(SW-1){1'b0}}};

    // Window midpoint, computed one bit wider so max+min cannot overflow.
    function automatic logic signed [SW:0] centre(input logic signed [SW-1:0] mn,
                                                  input logic signed [SW-1:0] mx);
        logic signed [SW:0] sum;
        sum = {mx[SW-1], mx} + {mn[SW-1], mn};
        return sum >>> 1;
    endfunction

    function automatic logic signed [SW-1:0] shrink(input logic signed [SW-1:0] bound,
                                                    input logic signed [SW:0]   c,
                                                    input logic [2:0]           sh);
        logic signed [SW:0] d;
        logic signed [SW:0] r;
        d = {bound[SW-1], bound} - c;
        d = d >>> sh;
        r = d + c;
        return r[SW-1:0];
    endfunction

    logic [COUNT_WIDTH-1:0] count;
    logic [COUNT_WIDTH-1:0] win_len;
    logic [COUNT_WIDTH-1:0] win_len_load;
    logic [4:0]             lc_eff;
    logic                   accept;
    logic                   last;
    logic                   vld_p0;

    logic signed [SW-1:0] lane      [CHANNELS];
    logic signed [SW-1:0] run_min   [CHANNELS];
    logic signed [SW-1:0] run_max   [CHANNELS];
    logic signed [SW-1:0] min_nxt   [CHANNELS];
    logic signed [SW-1:0] max_nxt   [CHANNELS];
    logic signed [SW-1:0] snap_min_p0 [CHANNELS];
    logic signed [SW-1:0] snap_max_p0 [CHANNELS];
    logic signed [SW-1:0] lower_p1  [CHANNELS];
    logic signed [SW-1:0] upper_p1  [CHANNELS];

    assign S_AXIS_tready = ~areset;
    assign accept        = S_AXIS_tvalid & ~areset;
    assign last          = (count == win_len - 1'b1);

    always_comb begin
        lc_eff = log_count;
        if (int'(log_count) > COUNT_WIDTH - 1)
            lc_eff = 5'(COUNT_WIDTH - 1);
        win_len_load = {{(COUNT_WIDTH-1){1'b0}}, 1'b1} << lc_eff;
    end

    always_comb begin
        for (int k = 0; k < CHANNELS; k++) begin
            lane[k]    = S_AXIS_tdata[k*SW +: SW];
            min_nxt[k] = (lane[k] < run_min[k]) ? lane[k] : run_min[k];
            max_nxt[k] = (lane[k] > run_max[k]) ? lane[k] : run_max[k];
            lower_threshold[k*SW +: SW] = lower_p1[k];
            upper_threshold[k*SW +: SW] = upper_p1[k];
        end
    end

    // Stage p0: accumulate extremes; on the closing beat hand the window to CALC.
    always_ff @(posedge aclk) begin
        if (areset) begin
            count            <= '0;
            win_len          <= win_len_load;
            vld_p0           <= 1'b0;
            update           <= 1'b0;
            thresholds_valid <= 1'b0;
            for (int k = 0; k < CHANNELS; k++) begin
                run_min[k]  <= POS_MAX;
                run_max[k]  <= NEG_MIN;
                lower_p1[k] <= POS_MAX;
                upper_p1[k] <= NEG_MIN;
            end
        end else begin
            vld_p0 <= 1'b0;
            if (clear || (accept && last)) begin
                count   <= '0;
                win_len <= win_len_load;
                for (int k = 0; k < CHANNELS; k++) begin
                    run_min[k] <= POS_MAX;
                    run_max[k] <= NEG_MIN;
                end
                vld_p0 <= ~clear;
            end else if (accept) begin
                count <= count + 1'b1;
                for (int k = 0; k < CHANNELS; k++) begin
                    run_min[k] <= min_nxt[k];
                    run_max[k] <= max_nxt[k];
                end
            end
            // Stage p1: thresholds from the snapshot taken on the previous edge.
            update <= vld_p0;
            if (vld_p0) begin
                thresholds_valid <= 1'b1;
                for (int k = 0; k < CHANNELS; k++) begin
                    lower_p1[k] <= shrink(snap_min_p0[k], centre(snap_min_p0[k], snap_max_p0[k]), shift);
                    upper_p1[k] <= shrink(snap_max_p0[k], centre(snap_min_p0[k], snap_max_p0[k]), shift);
                end
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (accept && last && !clear) begin
            for (int k = 0; k < CHANNELS; k++) begin
                snap_min_p0[k] <= min_nxt[k];
                snap_max_p0[k] <= max_nxt[k];
            end
        end
    end
endmodule

// File: tb/tb_axis_extremum_tracker.sv
// Directed bench for axis_extremum_tracker (2 lanes of 16 bits); inputs change and outputs are
// observed on the falling clock edge.
module tb_axis_extremum_tracker;
    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic [4:0]  log_count = 5'd2;
    logic [2:0]  shift = 3'd0;
    logic        clear = 1'b0;
    logic [31:0] lower_threshold;
    logic [31:0] upper_threshold;
    logic        thresholds_valid;
    logic        update;
    logic        S_AXIS_tvalid = 1'b0;
    logic [31:0] S_AXIS_tdata = '0;
    logic        S_AXIS_tready;

    int checks = 0;
    int errors = 0;

    axis_extremum_tracker #(.SAMPLE_WIDTH(16), .CHANNELS(2), .COUNT_WIDTH(32)) dut (
        .aclk(aclk), .areset(areset), .log_count(log_count), .shift(shift), .clear(clear),
        .lower_threshold(lower_threshold), .upper_threshold(upper_threshold),
        .thresholds_valid(thresholds_valid), .update(update),
        .S_AXIS_tvalid(S_AXIS_tvalid), .S_AXIS_tdata(S_AXIS_tdata), .S_AXIS_tready(S_AXIS_tready)
    );

    always #5 aclk = ~aclk;

    function automatic logic [31:0] pk(input int l1, input int l0);
        logic [15:0] a, b;
        a = 16'(l1);
        b = 16'(l0);
        return {a, b};
    endfunction

    task automatic send(input int l0, input int l1, input logic clr);
        @(negedge aclk);
        S_AXIS_tvalid = 1'b1;
        S_AXIS_tdata  = pk(l1, l0);
        clear         = clr;
    endtask

    task automatic idle(input logic clr);
        @(negedge aclk);
        S_AXIS_tvalid = 1'b0;
        clear         = clr;
    endtask

    task automatic test_reset;
        areset = 1'b1;
        repeat (3) @(negedge aclk);
        checks++; if (S_AXIS_tready !== 1'b0) begin errors++; $display("FAIL reset_tready got %b want 0", S_AXIS_tready); end
        checks++; if (lower_threshold !== 32'h7FFF7FFF) begin errors++; $display("FAIL reset_lower got %h want 7fff7fff", lower_threshold); end
        checks++; if (upper_threshold !== 32'h80008000) begin errors++; $display("FAIL reset_upper got %h want 80008000", upper_threshold); end
        checks++; if (thresholds_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", thresholds_valid); end
        checks++; if (update !== 1'b0) begin errors++; $display("FAIL reset_update got %b want 0", update); end
        areset = 1'b0;
        #1;
        checks++; if (S_AXIS_tready !== 1'b1) begin errors++; $display("FAIL run_tready got %b want 1", S_AXIS_tready); end
    endtask

    task automatic test_basic;
        send(10, 1, 0); send(-20, 2, 0); send(30, 3, 0); send(5, 4, 0);
        idle(0);
        checks++; if (update !== 1'b0) begin errors++; $display("FAIL basic_update_E got %b want 0", update); end
        idle(0);
        checks++; if (update !== 1'b1) begin errors++; $display("FAIL basic_update got %b want 1", update); end
        checks++; if (lower_threshold !== pk(1, -20)) begin errors++; $display("FAIL basic_lower got %h want %h", lower_threshold, pk(1, -20)); end
        checks++; if (upper_threshold !== pk(4, 30)) begin errors++; $display("FAIL basic_upper got %h want %h", upper_threshold, pk(4, 30)); end
        checks++; if (thresholds_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", thresholds_valid); end
        idle(0);
        checks++; if (update !== 1'b0) begin errors++; $display("FAIL basic_update_pulse got %b want 0", update); end
    endtask

    task automatic test_shrink;
        shift = 3'd2;
        send(10, -100, 0); send(-20, 300, 0); send(30, 0, 0); send(5, 50, 0);
        idle(0); idle(0);
        // lane0: c=5, lower=(-25>>>2)+5=-2, upper=(25>>>2)+5=11; lane1: c=100 -> 50/150
        checks++; if (update !== 1'b1) begin errors++; $display("FAIL shrink_update got %b want 1", update); end
        checks++; if (lower_threshold !== pk(50, -2)) begin errors++; $display("FAIL shrink_lower got %h want %h", lower_threshold, pk(50, -2)); end
        checks++; if (upper_threshold !== pk(150, 11)) begin errors++; $display("FAIL shrink_upper got %h want %h", upper_threshold, pk(150, 11)); end
        shift = 3'd0;
    endtask

    task automatic test_gaps;
        int gaps [8] = '{1, 0, 2, 0, 1, 3, 0, 0};
        log_count = 5'd3;
        idle(1);
        idle(0);
        checks++; if (lower_threshold !== pk(50, -2)) begin errors++; $display("FAIL clear_keeps_lower got %h want %h", lower_threshold, pk(50, -2)); end
        for (int i = 0; i < 8; i++) begin
            send(i + 1, -(i + 1), 0);
            checks++; if (update !== 1'b0) begin errors++; $display("FAIL gaps_early_update beat %0d got %b want 0", i, update); end
            for (int g = 0; g < gaps[i]; g++) begin
                idle(0);
                checks++; if (update !== 1'b0) begin errors++; $display("FAIL gaps_idle_update beat %0d got %b want 0", i, update); end
            end
        end
        idle(0);
        checks++; if (update !== 1'b0) begin errors++; $display("FAIL gaps_update_E got %b want 0", update); end
        idle(0);
        checks++; if (update !== 1'b1) begin errors++; $display("FAIL gaps_update got %b want 1", update); end
        checks++; if (lower_threshold !== pk(-8, 1)) begin errors++; $display("FAIL gaps_lower got %h want %h", lower_threshold, pk(-8, 1)); end
        checks++; if (upper_threshold !== pk(-1, 8)) begin errors++; $display("FAIL gaps_upper got %h want %h", upper_threshold, pk(-1, 8)); end
        idle(0);
        checks++; if (update !== 1'b0) begin errors++; $display("FAIL gaps_update_pulse got %b want 0", update); end
    endtask

    task automatic test_boundary;
        log_count = 5'd0;
        idle(1);
        send(7, -3, 0);
        send(-7, 100, 0);
        checks++; if (update !== 1'b0) begin errors++; $display("FAIL b2b_first got %b want 0", update); end
        send(32767, -32768, 0);
        checks++; if (update !== 1'b1 || lower_threshold !== pk(-3, 7) || upper_threshold !== pk(-3, 7)) begin
            errors++; $display("FAIL b2b_beat0 upd %b lo %h hi %h want 1 %h", update, lower_threshold, upper_threshold, pk(-3, 7)); end
        idle(0);
        checks++; if (update !== 1'b1 || lower_threshold !== pk(100, -7) || upper_threshold !== pk(100, -7)) begin
            errors++; $display("FAIL b2b_beat1 upd %b lo %h hi %h want 1 %h", update, lower_threshold, upper_threshold, pk(100, -7)); end
        idle(0);
        checks++; if (update !== 1'b1 || lower_threshold !== pk(-32768, 32767) || upper_threshold !== pk(-32768, 32767)) begin
            errors++; $display("FAIL b2b_beat2 upd %b lo %h hi %h want 1 %h", update, lower_threshold, upper_threshold, pk(-32768, 32767)); end
        idle(0);
        checks++; if (update !== 1'b0) begin errors++; $display("FAIL b2b_end got %b want 0", update); end
        log_count = 5'd1;
        idle(1);
        send(-32768, 32767, 0); send(32767, -32768, 0);
        idle(0); idle(0);
        checks++; if (lower_threshold !== 32'h80008000) begin errors++; $display("FAIL extreme_lower got %h want 80008000", lower_threshold); end
        checks++; if (upper_threshold !== 32'h7FFF7FFF) begin errors++; $display("FAIL extreme_upper got %h want 7fff7fff", upper_threshold); end
    endtask

    task automatic test_clear;
        log_count = 5'd2;
        idle(1);
        send(1000, -1000, 0); send(1000, -1000, 0); send(5000, -5000, 1);
        for (int i = 0; i < 4; i++) begin
            send(i + 1, -(i + 1), 0);
            checks++; if (update !== 1'b0) begin errors++; $display("FAIL clear_early_update beat %0d got %b want 0", i, update); end
        end
        idle(0);
        checks++; if (update !== 1'b0) begin errors++; $display("FAIL clear_update_E got %b want 0", update); end
        idle(0);
        checks++; if (update !== 1'b1) begin errors++; $display("FAIL clear_update got %b want 1", update); end
        checks++; if (lower_threshold !== pk(-4, 1)) begin errors++; $display("FAIL clear_lower got %h want %h", lower_threshold, pk(-4, 1)); end
        checks++; if (upper_threshold !== pk(-1, 4)) begin errors++; $display("FAIL clear_upper got %h want %h", upper_threshold, pk(-1, 4)); end
    endtask

    task automatic test_reset_mid;
        send(3, 3, 0); send(4, 4, 0); send(5, 5, 0); send(6, 6, 0);
        areset = 1'b1;
        idle(0);
        checks++; if (update !== 1'b0 || thresholds_valid !== 1'b0) begin errors++; $display("FAIL rstE_flags upd %b vld %b want 0 0", update, thresholds_valid); end
        checks++; if (lower_threshold !== 32'h7FFF7FFF || upper_threshold !== 32'h80008000) begin
            errors++; $display("FAIL rstE_thresholds lo %h hi %h want 7fff7fff 80008000", lower_threshold, upper_threshold); end
        areset = 1'b0;
        idle(0);
        checks++; if (update !== 1'b0) begin errors++; $display("FAIL rstE_update_after got %b want 0", update); end
        send(3, 3, 0); send(4, 4, 0); send(5, 5, 0); send(6, 6, 0);
        idle(0);
        areset = 1'b1;
        idle(0);
        checks++; if (update !== 1'b0 || thresholds_valid !== 1'b0) begin errors++; $display("FAIL rstCalc_flags upd %b vld %b want 0 0", update, thresholds_valid); end
        checks++; if (lower_threshold !== 32'h7FFF7FFF) begin errors++; $display("FAIL rstCalc_lower got %h want 7fff7fff", lower_threshold); end
        areset = 1'b0;
        idle(0);
        checks++; if (update !== 1'b0) begin errors++; $display("FAIL rstCalc_update_after got %b want 0", update); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_shrink;
        test_gaps;
        test_boundary;
        test_clear;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
